// File: rtl/d_cache_burst.sv
// Two-way set-associative write-back data cache with multi-word lines refilled/evicted by AXI INCR bursts.
// Optional uncached window (data_addr[31:29] == 3'b101) enabled by defining DCACHE_UNCACHED_EN.
module d_cache_burst #(
  parameter int unsigned INDEX_WIDTH  = 7,
  parameter int unsigned OFFSET_WIDTH = 4,
  parameter int unsigned TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_en,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        stall,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);
  localparam int unsigned SETS   = 1 << INDEX_WIDTH;
  localparam int unsigned WORDS  = 1 << (OFFSET_WIDTH - 2);
  localparam int unsigned WORD_W = (OFFSET_WIDTH > 2) ? OFFSET_WIDTH - 2 : 1;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_WB, S_REFILL, S_UNC_RD, S_UNC_WR} state_t;

  logic [SETS-1:0]      valid_q [2];
  logic [SETS-1:0]      dirty_q [2];
  logic [SETS-1:0]      lru_q;
  logic [TAG_WIDTH-1:0] tag_q  [2][SETS];
  logic [31:0]          data_q [2][SETS][WORDS];

  state_t              state_q, state_d;
  logic                victim_q, victim_d;
  logic [WORD_W-1:0]   bcnt_q, bcnt_d, rcnt_q, rcnt_d;
  logic                arvalid_q, arvalid_d, rready_q, rready_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_WIDTH-1:0]   tag_in;
  logic [WORD_W-1:0]      word;
  logic [1:0]             hit_way;
  logic                   hit, sel, uncached, uc_rd, uc_wr;
  logic [31:0]            cur_word, merged;
  logic                   store_hit, lru_we, lru_d, refill_we, refill_fin;
  logic                   unused_bits;

  assign idx         = data_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign tag_in      = data_addr[31 -: TAG_WIDTH];
  assign word        = (WORDS > 1) ? WORD_W'(data_addr >> 2) : '0;
  assign hit_way[0]  = valid_q[0][idx] & (tag_q[0][idx] == tag_in);
  assign hit_way[1]  = valid_q[1][idx] & (tag_q[1][idx] == tag_in);
  assign hit         = |hit_way;
  assign sel         = hit_way[1];
  assign cur_word    = data_q[sel][idx][word];
  assign unused_bits = ^{rlast, data_addr[1:0]};

`ifdef DCACHE_UNCACHED_EN
  assign uncached = (data_addr[31:29] == 3'b101);
`else
  assign uncached = 1'b0;
`endif

  assign uc_rd   = (state_q == S_UNC_RD);
  assign uc_wr   = (state_q == S_UNC_WR);
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign awvalid = awvalid_q;
  assign wvalid  = wvalid_q;
  assign bready  = aw_done_q & w_done_q;
  assign arsize  = 3'b010;
  assign awsize  = 3'b010;
  assign araddr  = uc_rd ? data_addr : {data_addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
  assign arlen   = uc_rd ? '0 : 8'(WORDS - 1);
  assign awaddr  = uc_wr ? data_addr : {tag_q[victim_q][idx], idx, {OFFSET_WIDTH{1'b0}}};
  assign awlen   = uc_wr ? '0 : 8'(WORDS - 1);
  assign wdata   = uc_wr ? data_wdata : data_q[victim_q][idx][bcnt_q];
  assign wstrb   = uc_wr ? data_wen : 4'hF;
  assign wlast   = wvalid_q & (uc_wr | (bcnt_q == LAST_WORD));

  always_comb begin
    merged = cur_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (data_wen[b]) merged[8*b +: 8] = data_wdata[8*b +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    bcnt_d     = bcnt_q;
    rcnt_d     = rcnt_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    stall      = 1'b0;
    data_rdata = cur_word;
    store_hit  = 1'b0;
    lru_we     = 1'b0;
    lru_d      = ~sel;
    refill_we  = 1'b0;
    refill_fin = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_en) begin
          if (uncached) begin
            stall = 1'b1;
            if (|data_wen) begin
              state_d   = S_UNC_WR;
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
            end else begin
              state_d   = S_UNC_RD;
              arvalid_d = 1'b1;
            end
          end else if (hit) begin
            store_hit = |data_wen;
            lru_we    = 1'b1;
          end else begin
            stall    = 1'b1;
            victim_d = lru_q[idx];
            if (valid_q[lru_q[idx]][idx] && dirty_q[lru_q[idx]][idx]) begin
              state_d   = S_WB;
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
              bcnt_d    = '0;
            end else begin
              state_d   = S_REFILL;
              arvalid_d = 1'b1;
              rcnt_d    = '0;
            end
          end
        end
      end
      S_WB, S_UNC_WR: begin
        stall = data_en;
        if (awvalid_q && awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && wready) begin
          if (uc_wr || bcnt_q == LAST_WORD) begin
            wvalid_d = 1'b0;
            w_done_d = 1'b1;
            bcnt_d   = '0;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        // bready is derived from the registered done flags, so B can only complete a cycle after both.
        if (bvalid && aw_done_q && w_done_q) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (uc_wr) begin
            stall   = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d   = S_REFILL;
            arvalid_d = 1'b1;
            rcnt_d    = '0;
          end
        end
      end
      S_REFILL, S_UNC_RD: begin
        stall = data_en;
        if (uc_rd) data_rdata = rdata;
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
        if (rready_q && rvalid) begin
          if (uc_rd) begin
            stall    = 1'b0;
            rready_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            refill_we = 1'b1;
            if (rcnt_q == LAST_WORD) begin
              refill_fin = 1'b1;
              lru_we     = 1'b1;
              lru_d      = ~victim_q;
              rready_d   = 1'b0;
              rcnt_d     = '0;
              state_d    = S_IDLE;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      victim_q  <= 1'b0;
      bcnt_q    <= '0;
      rcnt_q    <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      victim_q  <= victim_d;
      bcnt_q    <= bcnt_d;
      rcnt_q    <= rcnt_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      dirty_q[0] <= '0;
      dirty_q[1] <= '0;
      lru_q      <= '0;
    end else begin
      if (store_hit) dirty_q[sel][idx] <= 1'b1;
      if (lru_we) lru_q[idx] <= lru_d;
      if (refill_fin) begin
        valid_q[victim_q][idx] <= 1'b1;
        dirty_q[victim_q][idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store_hit) data_q[sel][idx][word] <= merged;
    if (refill_we) data_q[victim_q][idx][rcnt_q] <= rdata;
    if (refill_fin) tag_q[victim_q][idx] <= tag_in;
  end
endmodule

// File: tb/tb_d_cache_burst.sv
// Self-checking bench for d_cache_burst: AXI slave memory model plus a coherent reference memory scoreboard.
module tb_d_cache_burst;
  localparam int unsigned INDEX_WIDTH  = 7;
  localparam int unsigned OFFSET_WIDTH = 4;

  logic        clk, rst;
  logic        data_en, stall;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wen;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  d_cache_burst #(.INDEX_WIDTH(INDEX_WIDTH), .OFFSET_WIDTH(OFFSET_WIDTH)) dut (
    .clk(clk), .rst(rst), .data_en(data_en), .data_addr(data_addr), .data_wen(data_wen),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .stall(stall),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int seq   = 0;
  int unsigned r_beat = 0;

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_q   [$];
  logic [31:0] ar_addr_q [$];
  logic [7:0]  ar_len_q  [$];
  int          ar_seq_q  [$];
  logic [31:0] aw_addr_q [$];
  logic [7:0]  aw_len_q  [$];
  int          aw_seq_q  [$];
  logic        w_last_q  [$];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return pat(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return pat(a);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // AXI read slave: always ready for AR, back-to-back R beats
  initial begin
    logic har, hr, rs;
    logic [31:0] a, raddr;
    logic [7:0]  l, rlen;
    arready = 1'b1; rvalid = 1'b0; rlast = 1'b0; rdata = '0; raddr = '0; rlen = '0;
    forever begin
      @(negedge clk);
      har = arvalid & arready; hr = rvalid & rready; a = araddr; l = arlen; rs = rst;
      @(posedge clk); #1;
      if (!rs) begin
        rvalid = 1'b0; rlast = 1'b0;
      end else begin
        if (hr) begin
          if (r_beat == 32'(rlen)) begin
            rvalid = 1'b0; rlast = 1'b0;
          end else begin
            r_beat++;
            rdata = mem_rd(raddr + 32'(4 * r_beat));
            rlast = (r_beat == 32'(rlen));
          end
        end
        if (har) begin
          ar_addr_q.push_back(a); ar_len_q.push_back(l); ar_seq_q.push_back(seq); seq++;
          raddr = a; rlen = l; r_beat = 0; rvalid = 1'b1; rdata = mem_rd(a); rlast = (l == 8'd0);
        end
      end
    end
  end

  // AXI write slave: buffers W beats, commits to memory on the B handshake
  initial begin
    logic haw, hw, hb, ws, wl, aw_seen, wl_seen;
    logic [31:0] a, d, aw_a;
    logic [7:0]  l;
    logic [3:0]  s;
    logic [31:0] wd_buf [$];
    logic [3:0]  ws_buf [$];
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0; aw_seen = 1'b0; wl_seen = 1'b0; aw_a = '0;
    forever begin
      @(negedge clk);
      haw = awvalid & awready; hw = wvalid & wready; hb = bvalid & bready;
      a = awaddr; l = awlen; d = wdata; s = wstrb; wl = wlast; ws = rst;
      @(posedge clk); #1;
      if (!ws) begin
        bvalid = 1'b0; aw_seen = 1'b0; wl_seen = 1'b0; wd_buf.delete(); ws_buf.delete();
      end else begin
        if (hb) begin
          bvalid = 1'b0;
          for (int i = 0; i < wd_buf.size(); i++)
            mem[aw_a + 32'(4 * i)] = merge(mem_rd(aw_a + 32'(4 * i)), wd_buf[i], ws_buf[i]);
          wd_buf.delete(); ws_buf.delete(); aw_seen = 1'b0; wl_seen = 1'b0;
        end
        if (haw) begin
          aw_addr_q.push_back(a); aw_len_q.push_back(l); aw_seq_q.push_back(seq); seq++;
          aw_a = a; aw_seen = 1'b1;
        end
        if (hw) begin
          wd_buf.push_back(d); ws_buf.push_back(s); w_last_q.push_back(wl);
          if (wl) wl_seen = 1'b1;
        end
        if (aw_seen && wl_seen && !bvalid) bvalid = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic do_access(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wd, output int sc);
    logic [31:0] exp;
    bit done;
    @(posedge clk); #1;
    data_en = 1'b1; data_addr = addr; data_wen = wen; data_wdata = wd;
    if (wen == 4'h0) exp_q.push_back(ref_rd(addr));
    else ref_mem[addr] = merge(ref_rd(addr), wd, wen);
    sc = 0; done = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (!stall) done = 1; else sc++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL access_timeout: addr %h stalled %0d cycles, want completion", addr, sc);
      if (wen == 4'h0) exp = exp_q.pop_front();
    end else if (wen == 4'h0) begin
      exp = exp_q.pop_front();
      total++;
      if (data_rdata !== exp) begin
        bad++;
        $display("FAIL load_data @%h: got %h want %h", addr, data_rdata, exp);
      end
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    data_en = 1'b0; data_wen = '0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0; data_en = 1'b0; data_wen = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    ref_mem = mem;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    rst = 1'b0; data_en = 1'b0; data_addr = '0; data_wen = '0; data_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = {stall, arvalid, awvalid, wvalid, rready, bready, wlast};
    for (int i = 0; i < 7; i++) begin
      total++;
      if (got[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset_out%0d: got %b want 0", i, got[i]);
      end
    end
    @(posedge clk); #1 rst = 1'b1;
    ref_mem = mem;
  endtask

  task automatic test_cold_load();
    int sc, n0;
    n0 = ar_addr_q.size();
    do_access(32'h0000_1234, 4'h0, '0, sc);
    total++;
    if (sc != 6) begin bad++; $display("FAIL cold_stall: got %0d want 6", sc); end
    total++;
    if (ar_addr_q.size() != n0 + 1) begin
      bad++; $display("FAIL cold_ar_count: got %0d want %0d", ar_addr_q.size(), n0 + 1);
    end else begin
      total++;
      if (ar_addr_q[n0] !== 32'h0000_1230) begin bad++; $display("FAIL cold_araddr: got %h want 00001230", ar_addr_q[n0]); end
      total++;
      if (ar_len_q[n0] !== 8'd3) begin bad++; $display("FAIL cold_arlen: got %0d want 3", ar_len_q[n0]); end
    end
  endtask

  task automatic test_store_hit();
    int sc, nar, naw;
    nar = ar_addr_q.size(); naw = aw_addr_q.size();
    do_access(32'h0000_1238, 4'b0011, 32'hFFFF_EEEE, sc);
    total++;
    if (sc != 0) begin bad++; $display("FAIL store_hit_stall: got %0d want 0", sc); end
    do_access(32'h0000_1238, 4'h0, '0, sc);
    total++;
    if (ar_addr_q.size() != nar || aw_addr_q.size() != naw) begin
      bad++; $display("FAIL store_hit_axi: got ar=%0d aw=%0d want ar=%0d aw=%0d", ar_addr_q.size(), aw_addr_q.size(), nar, naw);
    end
    go_idle();
  endtask

  task automatic test_evict();
    int sc, nar, naw;
    logic [3:0] wl_pat;
    apply_reset();
    do_access(32'h0000_2A34, 4'h0, '0, sc);
    do_access(32'h0000_3238, 4'hF, 32'hDEAD_BEEF, sc);
    do_access(32'h0000_2A30, 4'h0, '0, sc);
    total++;
    if (sc != 0) begin bad++; $display("FAIL evict_touch_stall: got %0d want 0", sc); end
    nar = ar_addr_q.size(); naw = aw_addr_q.size();
    w_last_q.delete();
    do_access(32'h0000_3A3C, 4'h0, '0, sc);
    total++;
    if (aw_addr_q.size() != naw + 1 || ar_addr_q.size() != nar + 1) begin
      bad++; $display("FAIL evict_counts: got aw=%0d ar=%0d want aw=%0d ar=%0d", aw_addr_q.size(), ar_addr_q.size(), naw + 1, nar + 1);
    end else begin
      total++;
      if (aw_addr_q[naw] !== 32'h0000_3230) begin bad++; $display("FAIL evict_awaddr: got %h want 00003230", aw_addr_q[naw]); end
      total++;
      if (aw_len_q[naw] !== 8'd3) begin bad++; $display("FAIL evict_awlen: got %0d want 3", aw_len_q[naw]); end
      total++;
      if (ar_addr_q[nar] !== 32'h0000_3A30) begin bad++; $display("FAIL evict_araddr: got %h want 00003a30", ar_addr_q[nar]); end
      total++;
      if (ar_seq_q[nar] <= aw_seq_q[naw]) begin bad++; $display("FAIL evict_order: got ar seq %0d want after aw seq %0d", ar_seq_q[nar], aw_seq_q[naw]); end
    end
    total++;
    if (w_last_q.size() != 4) begin
      bad++; $display("FAIL evict_wbeats: got %0d want 4", w_last_q.size());
    end else begin
      wl_pat = {w_last_q[3], w_last_q[2], w_last_q[1], w_last_q[0]};
      total++;
      if (wl_pat !== 4'b1000) begin bad++; $display("FAIL evict_wlast: got %b want 1000", wl_pat); end
    end
    do_access(32'h0000_3238, 4'h0, '0, sc);
    total++;
    if (sc == 0) begin bad++; $display("FAIL evict_reload_miss: got stall %0d want >0", sc); end
    go_idle();
  endtask

  task automatic test_back_to_back();
    int sc, sum;
    logic [31:0] a;
    logic [3:0]  w;
    for (int i = 0; i < 5; i++) do_access(32'h0001_0000 + 32'(16 * i), 4'h0, '0, sc);
    sum = 0;
    for (int i = 0; i < 20; i++) begin
      a = 32'h0001_0000 + 32'(16 * $urandom_range(0, 4)) + 32'(4 * $urandom_range(0, 3));
      w = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      do_access(a, w, $urandom, sc);
      sum += sc;
    end
    total++;
    if (sum != 0) begin bad++; $display("FAIL b2b_stall: got %0d stall cycles want 0", sum); end
    go_idle();
  endtask

  task automatic test_reset_mid_burst();
    int sc, nar;
    bit found;
    logic [4:0] v;
    @(posedge clk); #1;
    data_en = 1'b1; data_addr = 32'h0005_0040; data_wen = '0;
    found = 0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (rvalid && rready && r_beat == 0) found = 1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL midrst_first_beat: got none want beat within 50 cycles"); end
    @(posedge clk); #1;
    rst = 1'b0; data_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    v = {arvalid, awvalid, wvalid, rready, bready};
    total++;
    if (v !== 5'b0) begin bad++; $display("FAIL midrst_valids: got %b want 00000", v); end
    @(posedge clk); #1 rst = 1'b1;
    ref_mem = mem;
    nar = ar_addr_q.size();
    do_access(32'h0005_0040, 4'h0, '0, sc);
    total++;
    if (ar_addr_q.size() != nar + 1 || sc == 0) begin
      bad++; $display("FAIL midrst_remiss: got ar=%0d stall=%0d want ar=%0d stall>0", ar_addr_q.size(), sc, nar + 1);
    end
    go_idle();
  endtask

`ifdef DCACHE_UNCACHED_EN
  task automatic test_uncached();
    int sc, nar;
    for (int k = 0; k < 2; k++) begin
      nar = ar_addr_q.size();
      do_access(32'hBFC0_0000, 4'h0, '0, sc);
      total++;
      if (ar_addr_q.size() != nar + 1) begin
        bad++; $display("FAIL unc_ar_count%0d: got %0d want %0d", k, ar_addr_q.size(), nar + 1);
      end else begin
        total++;
        if (ar_len_q[nar] !== 8'd0 || ar_addr_q[nar] !== 32'hBFC0_0000) begin
          bad++; $display("FAIL unc_ar%0d: got %h len %0d want bfc00000 len 0", k, ar_addr_q[nar], ar_len_q[nar]);
        end
      end
    end
    go_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit();
    test_evict();
    test_back_to_back();
    test_reset_mid_burst();
`ifdef DCACHE_UNCACHED_EN
    test_uncached();
`endif
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
